// File: rtl/lq_agen_arb.sv
// lq_agen_arb: round-robin arbiter for two load requesters feeding a two-stage
// pipeline that adds the low 12 address bits and forms the array index.
module lq_agen_arb #(
    parameter int TAG_WIDTH = 4
) (
    input  logic                 nclk,
    input  logic                 rst_b,
    input  logic                 r0_val,
    input  logic                 r1_val,
    output logic                 r0_rdy,
    output logic                 r1_rdy,
    input  logic [0:11]          r0_x,
    input  logic [0:11]          r0_y,
    input  logic [0:11]          r1_x,
    input  logic [0:11]          r1_y,
    input  logic                 r0_dir_ig_57,
    input  logic                 r1_dir_ig_57,
    input  logic [0:TAG_WIDTH-1] r0_tag,
    input  logic [0:TAG_WIDTH-1] r1_tag,
    input  logic                 flush,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [0:11]          out_sum,
    output logic [0:5]           out_sum_arr,
    output logic                 out_cout,
    output logic                 out_src,
    output logic [0:TAG_WIDTH-1] out_tag
);
    logic                 s1_val, s1_dir, s1_src, last_grant;
    logic [0:11]          s1_x, s1_y;
    logic [0:TAG_WIDTH-1] s1_tag;
    logic                 s2_val, s2_cout, s2_src;
    logic [0:11]          s2_sum;
    logic [0:5]           s2_arr;
    logic [0:TAG_WIDTH-1] s2_tag;
    logic [0:12]          sum13;
    logic                 g0, g1, s2_adv, s1_acc, x0, x1, xfer;

    // last_grant=1 means requester 1 won last, so requester 0 wins the next tie
    assign g0     = r0_val & (~r1_val | last_grant);
    assign g1     = r1_val & (~r0_val | ~last_grant);
    assign s2_adv = ~s2_val | out_rdy;
    assign s1_acc = (~s1_val | s2_adv) & ~flush;
    assign x0     = g0 & s1_acc;
    assign x1     = g1 & s1_acc;
    assign xfer   = x0 | x1;
    assign r0_rdy = x0 & rst_b;
    assign r1_rdy = x1 & rst_b;
    assign sum13  = {1'b0, s1_x} + {1'b0, s1_y};

    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            s1_val     <= 1'b0;
            s2_val     <= 1'b0;
            last_grant <= 1'b1;
            s1_x       <= '0;
            s1_y       <= '0;
            s1_dir     <= 1'b0;
            s1_src     <= 1'b0;
            s1_tag     <= '0;
            s2_sum     <= '0;
            s2_arr     <= '0;
            s2_cout    <= 1'b0;
            s2_src     <= 1'b0;
            s2_tag     <= '0;
        end else if (flush) begin
            s1_val <= 1'b0;
            s2_val <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_val <= s1_val;
                if (s1_val) begin
                    s2_sum  <= sum13[1:12];
                    s2_arr  <= {sum13[1:5], sum13[6] | s1_dir};
                    s2_cout <= sum13[0];
                    s2_src  <= s1_src;
                    s2_tag  <= s1_tag;
                end
            end
            if (s1_acc) s1_val <= xfer;
            if (xfer) begin
                s1_x       <= x1 ? r1_x : r0_x;
                s1_y       <= x1 ? r1_y : r0_y;
                s1_dir     <= x1 ? r1_dir_ig_57 : r0_dir_ig_57;
                s1_tag     <= x1 ? r1_tag : r0_tag;
                s1_src     <= x1;
                last_grant <= x1;
            end
        end
    end

    assign out_val     = s2_val;
    assign out_sum     = s2_sum;
    assign out_sum_arr = s2_arr;
    assign out_cout    = s2_cout;
    assign out_src     = s2_src;
    assign out_tag     = s2_tag;
endmodule

// File: tb/tb_lq_agen_arb.sv
// tb_lq_agen_arb: directed vector table plus hand-written multi-cycle
// sequences for arbitration, backpressure, flush and mid-operation reset.
module tb_lq_agen_arb;
    localparam int TW = 4;

    logic          nclk, rst_b, r0_val, r1_val, r0_rdy, r1_rdy;
    logic [0:11]   r0_x, r0_y, r1_x, r1_y;
    logic          r0_dir_ig_57, r1_dir_ig_57, flush, out_val, out_rdy, out_cout, out_src;
    logic [0:TW-1] r0_tag, r1_tag, out_tag;
    logic [0:11]   out_sum;
    logic [0:5]    out_sum_arr;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic        src;
        logic [11:0] x;
        logic [11:0] y;
        logic        dir;
        logic [3:0]  tag;
        logic [11:0] sum;
        logic [5:0]  arr;
        logic        cout;
    } vec_t;

    vec_t tv [7];

    lq_agen_arb #(.TAG_WIDTH(TW)) dut (
        .nclk(nclk), .rst_b(rst_b),
        .r0_val(r0_val), .r1_val(r1_val), .r0_rdy(r0_rdy), .r1_rdy(r1_rdy),
        .r0_x(r0_x), .r0_y(r0_y), .r1_x(r1_x), .r1_y(r1_y),
        .r0_dir_ig_57(r0_dir_ig_57), .r1_dir_ig_57(r1_dir_ig_57),
        .r0_tag(r0_tag), .r1_tag(r1_tag), .flush(flush),
        .out_val(out_val), .out_rdy(out_rdy), .out_sum(out_sum),
        .out_sum_arr(out_sum_arr), .out_cout(out_cout), .out_src(out_src), .out_tag(out_tag)
    );

    initial nclk = 1'b0;
    always #5 nclk = ~nclk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge nclk);
        #1;
    endtask

    task automatic clear_inputs;
        r0_val = 0; r1_val = 0; flush = 0; out_rdy = 1;
        r0_x = 0; r0_y = 0; r1_x = 0; r1_y = 0;
        r0_dir_ig_57 = 0; r1_dir_ig_57 = 0; r0_tag = 0; r1_tag = 0;
    endtask

    task automatic do_reset;
        @(negedge nclk);
        rst_b = 0;
        clear_inputs();
        tick();
        rst_b = 1;
    endtask

    task automatic chk_zero_outs(input string nm);
        chk({nm, "_val"}, out_val, 0);
        chk({nm, "_sum"}, out_sum, 0);
        chk({nm, "_arr"}, out_sum_arr, 0);
        chk({nm, "_cout"}, out_cout, 0);
        chk({nm, "_src"}, out_src, 0);
        chk({nm, "_tag"}, out_tag, 0);
    endtask

    initial begin
        tv[0] = '{1'b0, 12'h7F0, 12'h020, 1'b0, 4'h3, 12'h810, 6'h20, 1'b0};
        tv[1] = '{1'b1, 12'hFFF, 12'h002, 1'b1, 4'h5, 12'h001, 6'h01, 1'b1};
        tv[2] = '{1'b0, 12'h800, 12'h800, 1'b0, 4'hF, 12'h000, 6'h00, 1'b1};
        tv[3] = '{1'b1, 12'h123, 12'h456, 1'b0, 4'hA, 12'h579, 6'h15, 1'b0};
        tv[4] = '{1'b0, 12'h000, 12'h000, 1'b1, 4'h0, 12'h000, 6'h01, 1'b0};
        tv[5] = '{1'b1, 12'h03F, 12'h001, 1'b1, 4'h1, 12'h040, 6'h01, 1'b0};
        tv[6] = '{1'b0, 12'hFFF, 12'h001, 1'b0, 4'h7, 12'h000, 6'h00, 1'b1};

        rst_b = 0;
        clear_inputs();
        r0_val = 1;
        #3;
        chk_zero_outs("reset");
        chk("reset_r0_rdy", r0_rdy, 0);
        chk("reset_r1_rdy", r1_rdy, 0);
        tick();
        r0_val = 0;
        tick();
        rst_b = 1;

        // single operations straight after reset release, no backpressure
        foreach (tv[i]) begin
            r0_val = !tv[i].src; r1_val = tv[i].src;
            r0_x = tv[i].x; r1_x = tv[i].x; r0_y = tv[i].y; r1_y = tv[i].y;
            r0_dir_ig_57 = tv[i].dir; r1_dir_ig_57 = tv[i].dir;
            r0_tag = tv[i].tag; r1_tag = tv[i].tag;
            #1;
            chk($sformatf("v%0d_r0_rdy", i), r0_rdy, !tv[i].src);
            chk($sformatf("v%0d_r1_rdy", i), r1_rdy, tv[i].src);
            tick();
            r0_val = 0; r1_val = 0;
            chk($sformatf("v%0d_val_s1", i), out_val, 0);
            tick();
            chk($sformatf("v%0d_val", i), out_val, 1);
            chk($sformatf("v%0d_sum", i), out_sum, tv[i].sum);
            chk($sformatf("v%0d_arr", i), out_sum_arr, tv[i].arr);
            chk($sformatf("v%0d_cout", i), out_cout, tv[i].cout);
            chk($sformatf("v%0d_src", i), out_src, tv[i].src);
            chk($sformatf("v%0d_tag", i), out_tag, tv[i].tag);
        end
        tick();
        chk("table_drain_val", out_val, 0);

        // round-robin under constant contention
        do_reset();
        r0_tag = 1; r1_tag = 2;
        for (int c = 0; c < 7; c++) begin
            r0_val = c < 4; r1_val = c < 4;
            #1;
            if (c < 4) begin
                chk($sformatf("rr%0d_r0_rdy", c), r0_rdy, c % 2 == 0);
                chk($sformatf("rr%0d_r1_rdy", c), r1_rdy, c % 2 == 1);
            end
            if (c >= 2 && c < 6) begin
                chk($sformatf("rr%0d_val", c), out_val, 1);
                chk($sformatf("rr%0d_src", c), out_src, (c - 2) % 2);
                chk($sformatf("rr%0d_tag", c), out_tag, (c - 2) % 2 == 0 ? 1 : 2);
            end
            if (c == 6) chk("rr6_val", out_val, 0);
            tick();
        end

        // backpressure: out_rdy low for 5 cycles with r0 always valid
        do_reset();
        r0_y = 12'h001;
        for (int c = 0; c < 8; c++) begin
            r0_val = c < 5;
            r0_tag = (c == 0) ? 0 : 1;
            r0_x = (c == 0) ? 12'h000 : 12'h100;
            out_rdy = c >= 5;
            #1;
            if (c < 5) chk($sformatf("bp%0d_r0_rdy", c), r0_rdy, c < 2);
            if (c >= 2 && c <= 5) begin
                chk($sformatf("bp%0d_val", c), out_val, 1);
                chk($sformatf("bp%0d_tag", c), out_tag, 0);
                chk($sformatf("bp%0d_sum", c), out_sum, 12'h001);
            end
            if (c == 6) begin
                chk("bp6_val", out_val, 1);
                chk("bp6_tag", out_tag, 1);
                chk("bp6_sum", out_sum, 12'h101);
            end
            if (c == 7) chk("bp7_val", out_val, 0);
            tick();
        end

        // flush with both stages full; last_grant must survive it
        do_reset();
        out_rdy = 0; r1_val = 1; r1_tag = 9; r0_tag = 6;
        tick();
        tick();
        r0_val = 1; r1_val = 1; out_rdy = 1; flush = 1;
        #1;
        chk("fl_r0_rdy", r0_rdy, 0);
        chk("fl_r1_rdy", r1_rdy, 0);
        chk("fl_val_before", out_val, 1);
        tick();
        flush = 0;
        #1;
        chk("fl_val_after", out_val, 0);
        chk("fl_next_r0_rdy", r0_rdy, 1);
        chk("fl_next_r1_rdy", r1_rdy, 0);
        tick();
        r0_val = 0; r1_val = 0;
        chk("fl_no_stale", out_val, 0);
        tick();
        chk("fl_res_val", out_val, 1);
        chk("fl_res_src", out_src, 0);
        chk("fl_res_tag", out_tag, 6);
        tick();
        chk("fl_drain_val", out_val, 0);

        // asynchronous reset while both stages are full
        do_reset();
        out_rdy = 0; r0_val = 1; r0_x = 12'h555; r0_y = 12'h111; r0_tag = 4'hC; r0_dir_ig_57 = 1;
        tick();
        tick();
        r0_val = 0;
        chk("ar_full_val", out_val, 1);
        chk("ar_full_sum", out_sum, 12'h666);
        #2;
        rst_b = 0;
        #1;
        chk_zero_outs("ar_async");
        #1;
        rst_b = 1;
        out_rdy = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_zero_outs($sformatf("ar_idle%0d", c));
        end
        r1_val = 1; r1_x = 12'h00A; r1_y = 12'h005; r1_tag = 4; r1_dir_ig_57 = 0;
        #1;
        chk("ar_new_r1_rdy", r1_rdy, 1);
        tick();
        r1_val = 0;
        tick();
        chk("ar_new_val", out_val, 1);
        chk("ar_new_sum", out_sum, 12'h00F);
        chk("ar_new_src", out_src, 1);
        chk("ar_new_tag", out_tag, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
